// File: rtl/shift6_piso_tx.sv
// Parallel-in, serial-out shift transmitter: loads a word on a valid/ready
// handshake and sends it LSB first, one bit per shift_en cycle, with optional parity.
module shift6_piso_tx #(
   parameter int WIDTH      = 6,
   parameter bit PARITY_EN  = 1'b0,
   parameter bit PARITY_ODD = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_in,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic             shift_en,
   output logic             shift_out,
   output logic             busy,
   output logic             done
);

   localparam int CNT_W = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, SHIFT, PARITY, DONE} state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] shreg;
   logic [CNT_W-1:0] bit_cnt;
   logic             par;
   logic             last_bit;

   function automatic logic calc_par(input logic [WIDTH-1:0] d);
      return (^d) ^ PARITY_ODD;
   endfunction

   assign last_bit = (bit_cnt == CNT_W'(WIDTH - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Outputs depend on the state register only, never on the inputs.
   always_comb begin
      state_nxt  = state;
      load_ready = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      shift_out  = 1'b0;
      case (state)
         IDLE: begin
            load_ready = 1'b1;
            if (load_valid) state_nxt = SHIFT;
         end
         SHIFT: begin
            busy      = 1'b1;
            shift_out = shreg[0];
            if (shift_en && last_bit) state_nxt = PARITY_EN ? PARITY : DONE;
         end
         PARITY: begin
            busy      = 1'b1;
            shift_out = par;
            if (shift_en) state_nxt = DONE;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // The counter stops at WIDTH-1 so it can never wrap for any legal WIDTH.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shreg   <= '0;
         bit_cnt <= '0;
         par     <= 1'b0;
      end else if (state == IDLE && load_valid) begin
         shreg   <= data_in;
         bit_cnt <= '0;
         par     <= calc_par(data_in);
      end else if (state == SHIFT && shift_en) begin
         shreg <= {1'b0, shreg[WIDTH-1:1]};
         if (!last_bit) bit_cnt <= bit_cnt + 1'b1;
      end
   end

endmodule
